// File: rtl/mem_bus_interface_pkg.sv
// Shared definitions for the core-to-bus memory bridge: address-source codes
// (matching the control unit) and the bridge FSM state encoding.
package mem_bus_interface_pkg;

    localparam logic ADRSRC_PC  = 1'b0;
    localparam logic ADRSRC_ALU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } bus_state_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_bus_interface_bus_timeout_counter.sv
// Cycle counter for an outstanding bus request; flags expiry on the last
// allowed wait cycle and saturates there so it can never wrap.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST_COUNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST_COUNT);

endmodule

// File: rtl/mem_bus_interface.sv
// Bridges the multicycle core's unified memory port to an ack-based bus:
// one transaction per request, held read data, done/misaligned/timeout pulses.
module mem_bus_interface
    import mem_bus_interface_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic              adrsource,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              misaligned,
    output logic              timeout,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    bus_state_t        state_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              done_reg;
    logic              busy_reg;
    logic              misaligned_reg;
    logic              timeout_reg;
    logic              bus_req_reg;
    logic              bus_we_reg;
    logic [DATA_W-1:0] bus_addr_reg;
    logic [DATA_W-1:0] bus_wdata_reg;

    logic [DATA_W-1:0] addr_next;
    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_expired;

    always_comb begin
        addr_next = (adrsource == ADRSRC_ALU) ? alu_result : pc;
    end

    // Counter is held at zero while idle so it starts from zero on REQ entry.
    assign cnt_clear  = (state_reg == ST_IDLE);
    assign cnt_enable = (state_reg == ST_REQ);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(cnt_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            rdata_reg      <= '0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= '0;
            bus_wdata_reg  <= '0;
        end else begin
            done_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        bus_addr_reg  <= addr_next;
                        bus_we_reg    <= req_we;
                        bus_wdata_reg <= wdata;
                        busy_reg      <= 1'b1;
                        if (is_word_aligned(addr_next[1:0])) begin
                            bus_req_reg <= 1'b1;
                            state_reg   <= ST_REQ;
                        end else begin
                            misaligned_reg <= 1'b1;
                            done_reg       <= 1'b1;
                            state_reg      <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack in the final wait cycle still completes normally.
                    if (bus_ack) begin
                        if (!bus_we_reg) begin
                            rdata_reg <= bus_rdata;
                        end
                        bus_req_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else if (cnt_expired) begin
                        bus_req_reg <= 1'b0;
                        timeout_reg <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg    <= 1'b0;
                    bus_req_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata      = rdata_reg;
    assign done       = done_reg;
    assign busy       = busy_reg;
    assign misaligned = misaligned_reg;
    assign timeout    = timeout_reg;
    assign bus_req    = bus_req_reg;
    assign bus_we     = bus_we_reg;
    assign bus_addr   = bus_addr_reg;
    assign bus_wdata  = bus_wdata_reg;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Randomized scoreboard bench for mem_bus_interface: a driver issues accesses,
// a bus slave/monitor checks the bus side, a done monitor checks completions.
module tb_mem_bus_interface;
    import mem_bus_interface_pkg::*;

    localparam int DATA_W = 32;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_we;
    logic              adrsource;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              busy;
    logic              misaligned;
    logic              timeout;
    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack = 1'b0;
    logic [DATA_W-1:0] bus_rdata = '0;

    always #5 clk = ~clk;

    mem_bus_interface #(
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .adrsource(adrsource), .pc(pc), .alu_result(alu_result), .wdata(wdata),
        .rdata(rdata), .done(done), .busy(busy), .misaligned(misaligned),
        .timeout(timeout), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          ack_delay;
        logic [31:0] ack_rdata;
        bit          mis;
        bit          tmo;
        logic [31:0] rdata_after;
        int          req_cycles;
        int          latency;
        int          issue_cnt;
        int          id;
    } txn_t;

    txn_t exp_q[$];
    txn_t bus_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cycle_cnt = 0;
    int          txn_id = 0;
    bit          prev_b2b = 1'b0;
    logic [31:0] rdata_model = '0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference model: outcome of an access from the interface rules alone.
    task automatic make_txn(input logic src, input logic [31:0] pcv, input logic [31:0] aluv,
                            input logic we, input logic [31:0] wd, input int delay,
                            input logic [31:0] rd, output txn_t t);
        t.addr      = (src == ADRSRC_ALU) ? aluv : pcv;
        t.we        = we;
        t.wdata     = wd;
        t.ack_delay = delay;
        t.ack_rdata = rd;
        t.mis       = (t.addr % 4) != 0;
        t.tmo       = !t.mis && (delay >= TMO);
        t.req_cycles = t.mis ? 0 : (t.tmo ? TMO : delay + 1);
        t.latency   = t.mis ? 1 : t.req_cycles + 1;
        if (!t.mis && !t.tmo && !we) rdata_model = rd;
        t.rdata_after = rdata_model;
        t.issue_cnt = 0;
        t.id        = 0;
    endtask

    task automatic scramble_inputs();
        adrsource  = 1'($urandom_range(0, 1));
        pc         = $urandom;
        alu_result = $urandom;
        req_we     = 1'($urandom_range(0, 1));
        wdata      = $urandom;
    endtask

    task automatic check_idle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: busy=%0b bus_req=%0b required 0/0", busy, bus_req);
        end
    endtask

    task automatic run_txn(input logic src, input logic [31:0] pcv, input logic [31:0] aluv,
                           input logic we, input logic [31:0] wd, input int delay,
                           input logic [31:0] rd, input bit keep_valid);
        txn_t t;
        int   n;
        bit   b2b_start;
        make_txn(src, pcv, aluv, we, wd, delay, rd, t);
        b2b_start = prev_b2b;
        if (!b2b_start) check_idle();
        t.issue_cnt = b2b_start ? cycle_cnt + 1 : cycle_cnt;
        t.id = txn_id;
        txn_id++;
        adrsource = src; pc = pcv; alu_result = aluv; req_we = we; wdata = wd;
        req_valid = 1'b1;
        exp_q.push_back(t);
        if (!t.mis) bus_q.push_back(t);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            // In a back-to-back start the first negedge precedes the sampling edge.
            if (done !== 1'b1 && !(b2b_start && n == 1)) scramble_inputs();
        end while (done !== 1'b1 && n < TMO + 10);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_wait: txn %0d no done within %0d cycles", t.id, n);
        end
        prev_b2b = keep_valid;
        if (!keep_valid) begin
            req_valid = 1'b0;
            scramble_inputs();
        end
    endtask

    task automatic reset_mid(input int r);
        txn_t t;
        make_txn(ADRSRC_ALU, 32'h0, 32'h200, 1'b0, 32'h0, 1000, 32'h0, t);
        t.req_cycles = r;
        check_idle();
        adrsource = ADRSRC_ALU; alu_result = 32'h200; pc = 32'h0; req_we = 1'b0;
        req_valid = 1'b1;
        bus_q.push_back(t);
        repeat (r) @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || rdata !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: bus_req=%0b busy=%0b rdata=%h done=%0b required 0/0/0/0",
                     bus_req, busy, rdata, done);
        end
        $display("reset during REQ after %0d cycles: bus_req=%0b busy=%0b rdata=%h",
                 r, bus_req, busy, rdata);
        reset = 1'b0;
        rdata_model = '0;
        prev_b2b = 1'b0;
    endtask

    // Bus slave and bus-side monitor.
    int bus_run = 0;
    always @(negedge clk) begin
        if (bus_req === 1'b1) begin
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bus_req: addr=%h, no bus cycle required", bus_addr);
            end else begin
                checks++;
                if (bus_addr !== bus_q[0].addr || bus_we !== bus_q[0].we ||
                    (bus_q[0].we && bus_wdata !== bus_q[0].wdata) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL bus_fields: addr=%h we=%0b wdata=%h busy=%0b required addr=%h we=%0b wdata=%h busy=1",
                             bus_addr, bus_we, bus_wdata, busy, bus_q[0].addr, bus_q[0].we,
                             bus_q[0].wdata);
                end
                bus_ack   = (bus_run == bus_q[0].ack_delay);
                bus_rdata = bus_ack ? bus_q[0].ack_rdata : $urandom;
            end
            bus_run++;
        end else begin
            if (bus_run > 0 && bus_q.size() > 0) begin
                checks++;
                if (bus_run != bus_q[0].req_cycles) begin
                    errors++;
                    $display("FAIL bus_req_length: high %0d cycles, required %0d",
                             bus_run, bus_q[0].req_cycles);
                end
                void'(bus_q.pop_front());
            end
            bus_run   = 0;
            bus_ack   = ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
        end
    end

    // Completion monitor.
    txn_t        mon_e;
    logic [31:0] rdata_cur = '0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            rdata_cur = '0;
        end else if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no access outstanding");
            end else begin
                mon_e = exp_q.pop_front();
                rdata_cur = mon_e.rdata_after;
                checks++;
                if (misaligned !== mon_e.mis || timeout !== mon_e.tmo) begin
                    errors++;
                    $display("FAIL flags: txn %0d misaligned=%0b timeout=%0b required %0b/%0b",
                             mon_e.id, misaligned, timeout, mon_e.mis, mon_e.tmo);
                end
                checks++;
                if (rdata !== mon_e.rdata_after) begin
                    errors++;
                    $display("FAIL rdata: txn %0d rdata=%h required %h",
                             mon_e.id, rdata, mon_e.rdata_after);
                end
                checks++;
                if (cycle_cnt - mon_e.issue_cnt != mon_e.latency || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL latency: txn %0d took %0d cycles busy=%0b required %0d busy=1",
                             mon_e.id, cycle_cnt - mon_e.issue_cnt, busy, mon_e.latency);
                end
                $display("txn %0d addr=%h we=%0b mis=%0b tmo=%0b rdata=%h latency=%0d",
                         mon_e.id, mon_e.addr, mon_e.we, misaligned, timeout, rdata,
                         cycle_cnt - mon_e.issue_cnt);
            end
        end else begin
            checks++;
            if (misaligned !== 1'b0 || timeout !== 1'b0 || rdata !== rdata_cur) begin
                errors++;
                $display("FAIL hold: misaligned=%0b timeout=%0b rdata=%h required 0/0/%h",
                         misaligned, timeout, rdata, rdata_cur);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcv;
        logic [31:0] aluv;
        int          sel;
        int          delay;
        reset = 1'b1;
        req_valid = 1'b0;
        adrsource = 1'b0; pc = '0; alu_result = '0; req_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== '0 || done !== 1'b0 || busy !== 1'b0 || misaligned !== 1'b0 ||
            timeout !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 ||
            bus_addr !== '0 || bus_wdata !== '0) begin
            errors++;
            $display("FAIL reset_state: rdata=%h done=%0b busy=%0b bus_req=%0b bus_addr=%h required all zero",
                     rdata, done, busy, bus_req, bus_addr);
        end
        reset = 1'b0;

        run_txn(ADRSRC_PC,  32'h40, 32'h0,   1'b0, 32'h0,        0,  32'h00500093, 1'b0);
        run_txn(ADRSRC_ALU, 32'h0,  32'h100, 1'b1, 32'hDEADBEEF, 3,  32'h12345678, 1'b0);
        run_txn(ADRSRC_ALU, 32'h0,  32'h102, 1'b0, 32'h0,        0,  32'h0,        1'b0);
        run_txn(ADRSRC_PC,  32'h80, 32'h0,   1'b0, 32'h0,        99, 32'hBAD0BAD0, 1'b0);
        run_txn(ADRSRC_ALU, 32'h0,  32'h44,  1'b0, 32'h0,        15, 32'hCAFEF00D, 1'b0);
        reset_mid(5);
        run_txn(ADRSRC_PC,  32'h8,  32'h0,   1'b0, 32'h0,        1,  32'h0BADCAFE, 1'b1);
        run_txn(ADRSRC_ALU, 32'h0,  32'h10, 1'b1, 32'h55AA55AA,  2,  32'h0,        1'b0);

        for (int i = 0; i < 60; i++) begin
            pcv  = $urandom;
            aluv = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                pcv[1:0]  = 2'b00;
                aluv[1:0] = 2'b00;
            end else begin
                pcv[1:0]  = 2'($urandom_range(1, 3));
                aluv[1:0] = 2'($urandom_range(1, 3));
            end
            sel = $urandom_range(0, 9);
            if (sel < 6)       delay = $urandom_range(0, 3);
            else if (sel < 8)  delay = $urandom_range(TMO - 2, TMO - 1);
            else if (sel == 8) delay = TMO;
            else               delay = TMO + 14;
            run_txn(1'($urandom_range(0, 1)), pcv, aluv, 1'($urandom_range(0, 1)),
                    $urandom, delay, $urandom,
                    (i != 59) && ($urandom_range(0, 2) == 0));
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d completions and %0d bus cycles outstanding, required 0/0",
                     exp_q.size(), bus_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
